// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register write-pending counters.
// Combinational reads with writeback bypass; busy/stall/issue_ready from counters.
module regfile_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int MAXPEND = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NRD-1:0]                rd_en,
    input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic [NRD-1:0]                rd_busy,
    output logic                          stall,
    input  logic                          issue_valid,
    input  logic [$clog2(NREGS)-1:0]      issue_rd,
    output logic                          issue_ready,
    input  logic                          wb_valid,
    input  logic [$clog2(NREGS)-1:0]      wb_addr,
    input  logic [XLEN-1:0]               wb_data,
    input  logic                          flush,
    output logic                          err_underflow
);

    localparam int AW = $clog2(NREGS);
    localparam int PW = $clog2(MAXPEND + 1);
    localparam logic [PW-1:0] MAXP = PW'(MAXPEND);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [PW-1:0]   cnt_q  [NREGS];
    logic [PW-1:0]   cnt_d  [NREGS];
    logic            err_q;
    logic            err_d;

    logic wb_en;
    logic issue_take;

    assign wb_en = wb_valid && (wb_addr != '0);

    always_comb begin
        issue_ready = (issue_rd == '0)
                   || (cnt_q[issue_rd] < MAXP)
                   || (wb_valid && (wb_addr == issue_rd));
    end

    assign issue_take = issue_valid && issue_ready && !flush
                     && (issue_rd != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // x0 is never counted, so its counter stays at its reset value.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = cnt_q[r]
                         + PW'(issue_take && (issue_rd == AW'(r)))
                         - PW'(wb_valid && (wb_addr == AW'(r))
                               && (cnt_q[r] != '0));
            end
        end
    end

    always_comb begin
        err_d = err_q | (wb_en && !flush && (cnt_q[wb_addr] == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          byp;

        assign a   = rd_addr[i*AW +: AW];
        assign byp = wb_valid && (wb_addr == a);

        assign rd_data[i*XLEN +: XLEN] = (a == '0) ? '0
                                       : byp       ? wb_data
                                       :             regs_q[a];

        // The last outstanding write landing this cycle is bypassed.
        assign rd_busy[i] = rd_en[i] && (a != '0) && (cnt_q[a] != '0)
                         && !(byp && (cnt_q[a] == ONE));
    end

    assign stall         = |rd_busy;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: per-cycle model compare
// plus hand-computed literal checks.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int MAXP  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 stall;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic                 issue_ready;
    logic                 wb_valid;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;
    logic                 err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .MAXPEND(MAXP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural values and pending-write counts.
    logic [XLEN-1:0] mreg [NREGS];
    int              mcnt [NREGS];
    bit              merr;

    function automatic logic [XLEN-1:0] e_rdata(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_valid && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    function automatic bit e_busy(input bit en, input logic [AW-1:0] a);
        if (!en || a == 0 || mcnt[a] == 0) return 0;
        if (wb_valid && wb_addr == a && mcnt[a] == 1) return 0;
        return 1;
    endfunction

    function automatic bit e_ready();
        if (issue_rd == 0) return 1;
        if (mcnt[issue_rd] < MAXP) return 1;
        return wb_valid && wb_addr == issue_rd;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mreg[r] <= '0;
                mcnt[r] <= 0;
            end
            merr <= 0;
        end else begin
            if (wb_valid && wb_addr != 0) begin
                mreg[wb_addr] <= wb_data;
                if (!flush && mcnt[wb_addr] == 0) merr <= 1;
            end
            for (int r = 1; r < NREGS; r++) begin
                int inc;
                int dec;
                inc = (issue_valid && e_ready() && issue_rd == r) ? 1 : 0;
                dec = (wb_valid && wb_addr == r && mcnt[r] > 0) ? 1 : 0;
                mcnt[r] <= flush ? 0 : mcnt[r] + inc - dec;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [NRD-1:0] eb;
        eb = '0;
        for (int i = 0; i < NRD; i++) begin
            eb[i] = e_busy(rd_en[i], rd_addr[i*AW +: AW]);
            chk("m_rdata", 64'(rd_data[i*XLEN +: XLEN]),
                64'(e_rdata(rd_addr[i*AW +: AW])));
            chk("m_busy", 64'(rd_busy[i]), 64'(eb[i]));
        end
        chk("m_stall", 64'(stall), 64'(|eb));
        chk("m_ready", 64'(issue_ready), 64'(e_ready()));
        chk("m_err", 64'(err_underflow), 64'(merr));
    end

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        issue_valid = 0; issue_rd = '0;
        wb_valid = 0; wb_addr = '0; wb_data = '0;
        flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        #1 rst_n = 0;
        #1 rst_n = 1;
    endtask

    task automatic rd0(input logic en, input logic [AW-1:0] a);
        rd_en[0] = en; rd_addr[AW-1:0] = a;
    endtask

    task automatic rd1(input logic en, input logic [AW-1:0] a);
        rd_en[1] = en; rd_addr[2*AW-1:AW] = a;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_valid = 1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Write / read / bypass / x0
        do_reset();
        rd0(1, 5);
        mid();
        chk("t1_rst_data", 64'(rd_data[31:0]), 64'h0);
        chk("t1_rst_busy", 64'(rd_busy), 64'h0);
        chk("t1_rst_ready", 64'(issue_ready), 64'h1);
        chk("t1_rst_stall", 64'(stall), 64'h0);
        tick();
        wb(5, 32'hDEADBEEF);
        mid();
        chk("t1_bypass", 64'(rd_data[31:0]), 64'hDEADBEEF);
        tick();
        wb_valid = 0; rd1(1, 5);
        mid();
        chk("t1_read0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("t1_read1", 64'(rd_data[63:32]), 64'hDEADBEEF);
        tick();
        wb(0, 32'h1234); rd0(1, 0);
        mid();
        chk("t1_x0_byp", 64'(rd_data[31:0]), 64'h0);
        tick();
        wb_valid = 0;
        mid();
        chk("t1_x0_read", 64'(rd_data[31:0]), 64'h0);
        chk("t1_err", 64'(err_underflow), 64'h1);
        tick();

        // RAW stall
        do_reset();
        issue_valid = 1; issue_rd = 7; rd0(1, 7);
        mid();
        chk("t2_same_cyc", 64'(rd_busy[0]), 64'h0);
        tick();
        issue_valid = 0;
        mid();
        chk("t2_busy", 64'(rd_busy[0]), 64'h1);
        chk("t2_stall", 64'(stall), 64'h1);
        tick();
        mid();
        chk("t2_stall2", 64'(stall), 64'h1);
        tick();
        wb(7, 32'h55);
        mid();
        chk("t2_wb_busy", 64'(rd_busy[0]), 64'h0);
        chk("t2_wb_data", 64'(rd_data[31:0]), 64'h55);
        tick();
        wb_valid = 0;
        mid();
        chk("t2_after", 64'(stall), 64'h0);
        chk("t2_after_d", 64'(rd_data[31:0]), 64'h55);
        chk("t2_err", 64'(err_underflow), 64'h0);
        tick();

        // WAW up to MAXPEND
        do_reset();
        issue_valid = 1; issue_rd = 3;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t3_fill_rdy", 64'(issue_ready), 64'h1);
            tick();
        end
        mid();
        chk("t3_full", 64'(issue_ready), 64'h0);
        tick();
        wb(3, 32'h10);
        mid();
        chk("t3_free_rdy", 64'(issue_ready), 64'h1);
        tick();
        issue_valid = 0; wb_valid = 0; rd0(1, 3);
        mid();
        chk("t3_still_full", 64'(issue_ready), 64'h0);
        chk("t3_busy", 64'(rd_busy[0]), 64'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            wb(3, 32'h20 + k);
            mid();
            chk("t3_drain_busy", 64'(rd_busy[0]), (k < 2) ? 64'h1 : 64'h0);
        end
        tick();
        wb_valid = 0;
        mid();
        chk("t3_empty_busy", 64'(rd_busy[0]), 64'h0);
        chk("t3_empty_rdy", 64'(issue_ready), 64'h1);
        chk("t3_data", 64'(rd_data[31:0]), 64'h22);
        tick();
        issue_valid = 1; issue_rd = 0; rd0(1, 0);
        mid();
        chk("t3_x0_rdy", 64'(issue_ready), 64'h1);
        tick();
        issue_valid = 0;
        mid();
        chk("t3_x0_busy", 64'(rd_busy[0]), 64'h0);
        tick();

        // Flush
        do_reset();
        issue_valid = 1; issue_rd = 4; tick();
        issue_rd = 9; tick();
        tick();
        issue_rd = 11; flush = 1; wb(9, 32'h77); rd0(1, 9);
        mid();
        tick();
        idle(); rd0(1, 9); rd1(1, 4);
        mid();
        chk("t4_stall", 64'(stall), 64'h0);
        chk("t4_data9", 64'(rd_data[31:0]), 64'h77);
        chk("t4_err", 64'(err_underflow), 64'h0);
        tick();
        rd1(1, 11);
        mid();
        chk("t4_busy11", 64'(rd_busy[1]), 64'h0);
        tick();

        // Underflow
        do_reset();
        wb(12, 32'hABC);
        tick();
        idle(); rd0(1, 12);
        mid();
        chk("t5_err", 64'(err_underflow), 64'h1);
        chk("t5_data", 64'(rd_data[31:0]), 64'hABC);
        repeat (3) tick();
        mid();
        chk("t5_sticky", 64'(err_underflow), 64'h1);
        tick();
        do_reset();
        mid();
        chk("t5_cleared", 64'(err_underflow), 64'h0);
        tick();

        // Async reset mid-cycle
        do_reset();
        issue_valid = 1; issue_rd = 6; tick();
        tick();
        issue_valid = 0; rd0(1, 6);
        mid();
        chk("t6_pre_stall", 64'(stall), 64'h1);
        #2 rst_n = 0;
        #1;
        chk("t6_stall", 64'(stall), 64'h0);
        chk("t6_data", 64'(rd_data[31:0]), 64'h0);
        chk("t6_ready", 64'(issue_ready), 64'h1);
        tick();
        rst_n = 1;
        tick();
        mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file with a built-in write-pending scoreboard for the pipelined core. It replaces the fixed 2-read/1-write register file and carries the RAW-hazard tracking that hazard detection otherwise recomputes. It provides:
- NRD combinational read ports with writeback bypass.
- One writeback port.
- Per-register in-flight write counters (so multiple WAW writes can be outstanding).
- Issue handshake, flush and a stall output.

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers; power of 2, ≥2. AW = log2(NREGS) is a derived localparam.
NRD, 2, number of read ports (≥1).
MAXPEND, 3, max outstanding writes per register; counter width PW = clog2(MAXPEND+1).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
rd_en  in  NRD  per-port read is real (operand used).
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW].
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
rd_busy  out  NRD  per-port operand still pending.
stall  out  1  OR of rd_busy.
issue_valid  in  1  instruction dispatched that will write issue_rd.
issue_rd  in  AW  destination of issuing instruction.
issue_ready  out  1  scoreboard can accept issue to issue_rd.
wb_valid  in  1  writeback strobe.
wb_addr  in  AW  writeback destination.
wb_data  in  XLEN  writeback data.
flush  in  1  discard all pending writes (mispredict/exception).
err_underflow  out  1  sticky: writeback arrived with zero pending count.

Behaviour:
Reset (rst_n=0, async):
- All registers and counters are cleared; err_underflow=0.
- Outputs settle to: rd_data=0, rd_busy=0, stall=0, issue_ready=1.
- Reset asserted mid-operation discards all state immediately.

Register x0:
- Reads return 0.
- Writes are ignored.
- Issues to x0 are accepted, never counted, and never set busy.

Reads (combinational, zero latency):
- rd_data[i] = 0 if addr==0.
- Otherwise rd_data[i] = wb_data if wb_valid && wb_addr==addr (bypass).
- Otherwise rd_data[i] = the stored register value.

Write:
- At posedge, if wb_valid && wb_addr!=0, then reg[wb_addr] <= wb_data.
- The write occurs regardless of counter state or flush.

Counters cnt[r], PW bits, updated at posedge:
- inc = issue_valid && issue_ready && issue_rd==r && r!=0 && !flush.
- dec = wb_valid && wb_addr==r && cnt[r]!=0.
- If flush: cnt <= 0 for all r, taking priority over inc and dec.
- Else: cnt[r] <= cnt[r] + inc − dec; inc and dec in the same cycle leave cnt unchanged.
- A writeback with cnt==0 and no flush sets err_underflow=1. The count does not go negative. err_underflow clears only on reset.

issue_ready:
- 1 if issue_rd==0.
- Otherwise 1 if cnt[issue_rd] < MAXPEND.
- Otherwise 1 if wb_valid && wb_addr==issue_rd (slot freed same cycle).
- Otherwise 0.
- Combinational; an issue is taken only when valid && ready.

rd_busy[i]:
- Asserted when rd_en[i] && addr!=0 && cnt[addr]!=0.
- Exception: rd_busy[i] is 0 when wb_valid && wb_addr==addr && cnt[addr]==1 (the last pending write is bypassed this cycle).
- Combinational. stall is the OR of all rd_busy bits.

Same-cycle issue and read of the same register:
- A read in that cycle does not see the new issue; busy is based on the registered cnt only.
- The consumer is stalled from the next cycle.

All outputs other than the sticky flag are combinational from state and inputs. No internal pipeline.

Test Plan:
1. Reset then write/read: after reset, read addr 5 → rd_data 0, busy 0. Writeback (wb 5, 0xDEADBEEF) in cycle 1; cycle 2 read 5 → 0xDEADBEEF. Also check: rd_addr=5 in cycle 1 → 0xDEADBEEF via bypass. Write to x0 with 0x1234 → read x0 = 0.
2. RAW stall: issue rd=7 in cycle 0. Cycle 1 read 7 with rd_en=1 → rd_busy=1, stall=1. Cycle 3 wb 7 = 0x55 → busy=0, rd_data=0x55 the same cycle. Cycle 4 → cnt=0, busy=0.
3. WAW / MAXPEND: issue rd=3 three times, then a 4th issue → issue_ready=0, cnt stays 3. A 4th issue concurrent with wb 3 → accepted, cnt=3. Three more wbs → cnt=0; a read of 3 is busy until the final wb cycle.
4. Flush: issue rd 4, 9, 9; flush together with issue rd 11 → next cycle all cnt=0, 11 not counted, stall=0. A wb 9 = 0x77 in the flush cycle still updates reg 9, and err_underflow stays 0.
5. Underflow: wb 12 with cnt=0 → reg 12 written, err_underflow=1 and stays 1 until rst_n pulse.
6. Async reset mid-operation: cnt[6]=2 with stall high; drop rst_n between clock edges → stall=0, rd_data=0 immediately, with no clock edge required.
